wave_sp_player: RTL and testbench

//   Parametrised waveform memory with a built-in playback sequencer for the arbitrary wave generator.

---
 rtl/wave_sp_player.sv | 130 +++++++++++++
 tb/tb_wave_sp_player.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sp_player.sv
// Waveform memory (single-port synchronous RAM) with a tick-paced playback sequencer.
// Playback reads own the port on tick cycles; host writes take every other cycle.
module wave_sp_player #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              loop_mode,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] rd_ptr, start_q, end_q;
  logic              loop_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic              rd_v1;
  logic              done_q;

  logic              in_run, load, issue, at_end, wr_en;
  logic [ADDR_W-1:0] ram_addr;

  assign in_run   = (state == RUN);
  assign load     = play_start & ~play_stop;
  // Stop and restart cycles both suppress the read that a tick would otherwise issue.
  assign issue    = in_run & sample_tick & ~play_stop & ~play_start;
  assign at_end   = (rd_ptr == end_q);
  assign wr_ready = ~(in_run & sample_tick);
  assign wr_en    = wr_valid & wr_ready;
  assign ram_addr = issue ? rd_ptr : wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (play_stop)       state_next = IDLE;
        else if (play_start) state_next = RUN;
      end
      RUN: begin
        if (play_stop)                         state_next = IDLE;
        else if (issue && at_end && !loop_q)   state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      start_q <= '0;
      end_q   <= '0;
      loop_q  <= 1'b0;
    end else if (load) begin
      start_q <= start_addr;
      end_q   <= end_addr;
      loop_q  <= loop_mode;
      rd_ptr  <= start_addr;
    end else if (issue) begin
      if (at_end) begin
        if (loop_q) rd_ptr <= start_q;
      end else begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q  <= '0;
      rd_v1  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rd_v1  <= issue;
      done_q <= issue & at_end & ~loop_q;
      if (issue) ram_q <= mem[ram_addr];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_q;
      logic              out_v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          out_v <= rd_v1;
          if (rd_v1) out_q <= ram_q;
        end
      end
      assign sample_data  = out_q;
      assign sample_valid = out_v;
    end else begin : g_lat1
      assign sample_data  = ram_q;
      assign sample_valid = rd_v1;
    end
  endgenerate

  assign busy = in_run;
  assign done = done_q;

endmodule

// File: tb/tb_wave_sp_player.sv
// Randomized bench for wave_sp_player: a spec-level playback model predicts every sample,
// its arrival cycle, done pulses, busy and wr_ready.
module tb_wave_sp_player;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 11;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              loop_mode = 1'b0;
  logic              play_start = 1'b0;
  logic              play_stop = 1'b0;
  logic              sample_tick = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              busy;
  logic              done;

  wave_sp_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .start_addr(start_addr), .end_addr(end_addr), .loop_mode(loop_mode),
    .play_start(play_start), .play_stop(play_stop), .sample_tick(sample_tick),
    .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [int];
  int m_state = M_IDLE, m_ptr = 0, m_start = 0, m_end = 0;
  bit m_loop = 1'b0;

  logic [DATA_W-1:0] exp_d[$], got_d[$];
  int exp_c[$], got_c[$], exp_done[$], got_done[$];

  always @(negedge clk) begin
    if (sample_valid) begin
      got_d.push_back(sample_data);
      got_c.push_back(cyc);
    end
    if (done) got_done.push_back(cyc);
  end

  // One clock cycle of stimulus; the model applies the same inputs under the playback rules.
  task automatic cyc_drive(input bit tick, input bit start, input bit stop,
                           input bit wv = 1'b0, input int wa = 0, input int wd = 0);
    bit exp_ready;
    sample_tick = tick;
    play_start  = start;
    play_stop   = stop;
    wr_valid    = wv;
    wr_addr     = ADDR_W'(wa);
    wr_data     = DATA_W'(wd);
    #1;
    exp_ready = !(m_state == M_RUN && tick);
    total++;
    if (wr_ready !== exp_ready) begin
      bad++;
      $display("FAIL wr_ready: got %b want %b at cycle %0d", wr_ready, exp_ready, cyc);
    end
    if (wv && exp_ready) ref_mem[wa] = DATA_W'(wd);
    if (stop) begin
      m_state = M_IDLE;
    end else if (start) begin
      m_start = int'(start_addr);
      m_end   = int'(end_addr);
      m_loop  = loop_mode;
      m_ptr   = m_start;
      m_state = M_RUN;
    end else if (tick && m_state == M_RUN) begin
      exp_d.push_back(ref_mem[m_ptr]);
      exp_c.push_back(cyc + RD_LAT);
      if (m_ptr == m_end) begin
        if (m_loop) m_ptr = m_start;
        else begin
          m_state = M_DONE;
          exp_done.push_back(cyc + 1);
        end
      end else begin
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== (m_state == M_RUN)) begin
      bad++;
      $display("FAIL busy: got %b want %b at cycle %0d", busy, (m_state == M_RUN), cyc);
    end
  endtask

  task automatic play(input int s, input int e, input bit l);
    start_addr = ADDR_W'(s);
    end_addr   = ADDR_W'(e);
    loop_mode  = l;
    cyc_drive(1'b0, 1'b1, 1'b0);
  endtask

  task automatic write_random(input int s, input int len);
    for (int i = 0; i < len; i++) cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, (s + i) % DEPTH, int'($urandom_range(1, 2**DATA_W - 1)));
  endtask

  // Let in-flight reads land, then score collected samples and done pulses against the model.
  task automatic drain_and_score(input string name);
    repeat (RD_LAT + 2) cyc_drive(1'b0, 1'b0, 1'b0);
    total++;
    if (got_d.size() != exp_d.size()) begin
      bad++;
      $display("FAIL %s sample count: got %0d want %0d", name, got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
        bad++;
        $display("FAIL %s sample %0d: got %0h@%0d want %0h@%0d", name, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
    total++;
    if (got_done.size() != exp_done.size()) begin
      bad++;
      $display("FAIL %s done count: got %0d want %0d", name, got_done.size(), exp_done.size());
    end
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      total++;
      if (got_done[i] != exp_done[i]) begin
        bad++;
        $display("FAIL %s done cycle: got %0d want %0d", name, got_done[i], exp_done[i]);
      end
    end
    exp_d.delete(); got_d.delete(); exp_c.delete(); got_c.delete();
    exp_done.delete(); got_done.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sample_data !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs: got data=%0h valid=%b busy=%b done=%b want all 0", sample_data, sample_valid, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset wr_ready: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_oneshot();
    for (int i = 0; i < 8; i++) cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, i, i);
    play(0, 7, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc_drive(1'b1, 1'b0, 1'b0);
      cyc_drive(1'b0, 1'b0, 1'b0);
      cyc_drive(1'b0, 1'b0, 1'b0);
    end
    cyc_drive(1'b1, 1'b0, 1'b0);
    drain_and_score("oneshot");
    total++;
    if (sample_data !== ref_mem[7]) begin
      bad++;
      $display("FAIL oneshot hold: got %0h want %0h", sample_data, ref_mem[7]);
    end
    cyc_drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_loop();
    write_random(2, 3);
    play(2, 4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc_drive(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) cyc_drive(1'b0, 1'b0, 1'b0);
    end
    drain_and_score("loop");
    cyc_drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    write_random(DEPTH - 2, 4);
    play(DEPTH - 2, 1, 1'b0);
    repeat (4) cyc_drive(1'b1, 1'b0, 1'b0);
    drain_and_score("wrap");
    cyc_drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      int s, len;
      s   = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(1, 12));
      write_random(s, len);
      play(s, (s + len - 1) % DEPTH, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(len, 3 * len)) cyc_drive(1'b1, 1'b0, 1'b0);
      drain_and_score("back_to_back");
      cyc_drive(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_arbitration();
    int nv;
    write_random(10, 3);
    nv = int'($urandom_range(0, 2**DATA_W - 1));
    play(10, 12, 1'b1);
    repeat (5) cyc_drive(1'b1, 1'b0, 1'b0, 1'b1, 11, nv);
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 11, nv);
    cyc_drive(1'b0, 1'b0, 1'b1);
    drain_and_score("arb_hold");
    play(10, 12, 1'b0);
    repeat (3) cyc_drive(1'b1, 1'b0, 1'b0);
    drain_and_score("arb_readback");
    cyc_drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_stop();
    cyc_drive(1'b0, 1'b1, 1'b1);
    repeat (3) cyc_drive(1'b1, 1'b0, 1'b0);
    play(0, 7, 1'b0);
    cyc_drive(1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 1'b0, 1'b1);
    repeat (3) cyc_drive(1'b1, 1'b0, 1'b0);
    drain_and_score("start_stop");
  endtask

  task automatic test_reset_midrun();
    write_random(5, 3);
    play(5, 7, 1'b1);
    repeat (3) cyc_drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (sample_data !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrun reset outputs: got data=%0h valid=%b busy=%b done=%b want all 0", sample_data, sample_valid, busy, done);
    end
    exp_d.delete(); got_d.delete(); exp_c.delete(); got_c.delete();
    exp_done.delete(); got_done.delete();
    m_state = M_IDLE;
    m_ptr   = 0;
    #2;
    rst_n = 1'b1;
    repeat (4) cyc_drive(1'b1, 1'b0, 1'b0);
    drain_and_score("midrun_reset");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_wrap();
    test_back_to_back();
    test_arbitration();
    test_start_stop();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
